uart_bus_bridge: RTL

- Host-side debug/loader port. Parses command frames arriving as bytes from the uart receiver and masters the CPU memory bus to perform single-byte reads and writes.
- Returns one response byte per frame through the uart transmitter.
- Sits between the uart block and the mmu/ram address path. It is the responder to a host PC acting as initiator. Top-level arbitration grants it the bus via a req/gnt pair.

---
 rtl/uart_bus_bridge.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_bus_bridge.sv
// Host debug port: parses 'W'/'R' command frames from the uart and performs
// single-byte memory bus accesses, returning one response byte per frame.
module uart_bus_bridge #(
  parameter int          RD_LATENCY     = 1,
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  output logic        busy
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA, REQ, ACCESS, RD_WAIT, TX, TX_WAIT
  } state_t;

  state_t        state, nxt;
  logic          wr_flag;
  logic [15:0]   addr;
  logic [7:0]    data;
  logic [TW-1:0] to_cnt;
  logic [2:0]    rd_cnt;
  logic          in_frame, to_hit, rd_last, cmd_ok;

  assign in_frame = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
  assign to_hit   = in_frame && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rd_last  = (rd_cnt == 3'(RD_LATENCY - 1));
  assign cmd_ok   = (rx_data == CMD_W) || (rx_data == CMD_R);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // rx_done is tested before the timeout so a byte arriving on the expiry cycle is kept
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (rx_done) nxt = cmd_ok ? ADDR_HI : TX;
      ADDR_HI: if (rx_done) nxt = ADDR_LO;
               else if (to_hit) nxt = IDLE;
      ADDR_LO: if (rx_done) nxt = wr_flag ? DATA : REQ;
               else if (to_hit) nxt = IDLE;
      DATA:    if (rx_done) nxt = REQ;
               else if (to_hit) nxt = IDLE;
      REQ:     if (bus_gnt) nxt = ACCESS;
      ACCESS:  nxt = wr_flag ? TX : RD_WAIT;
      RD_WAIT: if (rd_last) nxt = TX;
      TX:      nxt = TX_WAIT;
      TX_WAIT: if (tx_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_flag <= 1'b0;
      addr    <= '0;
      data    <= '0;
      to_cnt  <= '0;
      rd_cnt  <= '0;
      tx_data <= '0;
    end else begin
      if (state == IDLE && rx_done) begin
        wr_flag <= (rx_data == CMD_W);
        if (!cmd_ok) tx_data <= NAK_BYTE;
      end
      if (state == ADDR_HI && rx_done) addr[15:8] <= rx_data;
      if (state == ADDR_LO && rx_done) addr[7:0]  <= rx_data;
      if (state == DATA    && rx_done) data       <= rx_data;
      // counter idles at zero outside the frame, so it is clear on entry
      if (!in_frame || rx_done) to_cnt <= '0;
      else                      to_cnt <= to_cnt + 1'b1;
      rd_cnt <= (state == RD_WAIT) ? rd_cnt + 1'b1 : 3'd0;
      if (state == ACCESS && wr_flag) tx_data <= ACK_BYTE;
      if (state == RD_WAIT && rd_last) tx_data <= bus_di;
    end
  end

  // bus outputs are gated by the grant so nothing reaches the bus before ownership
  always_comb begin
    bus_req  = (state == REQ) || (state == ACCESS) || (state == RD_WAIT);
    bus_addr = '0;
    bus_we   = 1'b0;
    bus_do   = '0;
    if (bus_gnt && (state == ACCESS || state == RD_WAIT)) bus_addr = addr;
    if (bus_gnt && state == ACCESS && wr_flag) begin
      bus_we = 1'b1;
      bus_do = data;
    end
  end

  assign tx_wr = (state == TX);
  assign busy  = (state != IDLE);

endmodule
